// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and default operand width.
package serial_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder, purely combinational; the only arithmetic in the serial adder.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: LSB-first through one fa_cell, carry held in a flip-flop.
// Optional subtraction via `define SERIAL_SUB_EN (adds port sub).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-2:0] r_sum_sh;
  logic             r_c_ff;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_y;
  logic             w_s;
  logic             w_co;
  logic             w_load_c;
  logic [WIDTH-1:0] w_sum_next;

`ifdef SERIAL_SUB_EN
  logic r_sub;
  // Subtraction is a + ~b + 1: invert b at the cell input, force carry-in to 1.
  assign w_y      = r_b_sh[0] ^ r_sub;
  assign w_load_c = sub ? 1'b1 : cin;
`else
  assign w_y      = r_b_sh[0];
  assign w_load_c = cin;
`endif

  fa_cell u_fa (
    .x  (r_a_sh[0]),
    .y  (w_y),
    .ci (r_c_ff),
    .s  (w_s),
    .co (w_co)
  );

  // Keeping only WIDTH-1 stored sum bits; the newest bit comes straight from the cell.
  assign w_sum_next = {w_s, r_sum_sh};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_c_ff   <= 1'b0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
`ifdef SERIAL_SUB_EN
      r_sub    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_c_ff   <= w_load_c;
            r_cnt    <= '0;
            r_sum_sh <= '0;
`ifdef SERIAL_SUB_EN
            r_sub    <= sub;
`endif
            r_state  <= RUN;
          end else begin
            r_state  <= IDLE;
          end
        end
        RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_sum_sh <= w_sum_next[WIDTH-1:1];
          r_c_ff   <= w_co;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST) begin
            r_sum   <= w_sum_next;
            r_cout  <= w_co;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8); sub tests when SERIAL_SUB_EN is defined.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle, wait (bounded) for done, check latency and result.
  task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic icin, input logic isub,
                        input logic [W-1:0] esum, input logic ecout);
    int n;
    a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, W);
    check({tag, "_sum"}, {24'd0, sum}, {24'd0, esum});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, ecout});
    tick();
    check({tag, "_done1"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [W:0]   e;
    logic [W-1:0] ra, rb;
    logic         rc;
    int           n;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum",  {24'd0, sum},  32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    rst = 1'b0;
    tick();

    // Test 1: busy for exactly 8 cycles, then done
    a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t1_busy", {31'd0, busy}, 32'd1);
      check("t1_nodone", {31'd0, done}, 32'd0);
      tick();
    end
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_busy_off", {31'd0, busy}, 32'd0);
    check("t1_sum", {24'd0, sum}, 32'h96);
    check("t1_cout", {31'd0, cout}, 32'd0);
    tick();
    check("t1_done_pulse", {31'd0, done}, 32'd0);
    check("t1_sum_hold", {24'd0, sum}, 32'h96);

    // Test 2: carry propagation cases
    run_op("t2a", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    run_op("t2b", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    run_op("t2c", 8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1);
    run_op("t2d", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

    // Test 3: start held, operands changed mid-run, back-to-back op
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    tick();
    a = 8'h77; b = 8'h01;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("t3_lat1", n, 8);
    check("t3_sum1", {24'd0, sum}, 32'h33);
    check("t3_cout1", {31'd0, cout}, 32'd0);
    tick();
    start = 1'b0;
    check("t3_b2b_busy", {31'd0, busy}, 32'd1);
    check("t3_sum_stable", {24'd0, sum}, 32'h33);
    n = 1;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("t3_lat2", n, 9);
    check("t3_sum2", {24'd0, sum}, 32'h78);
    check("t3_cout2", {31'd0, cout}, 32'd0);
    tick();

    // Test 4: reset in the middle of RUN discards the operation
    a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("t4_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_done", {31'd0, done}, 32'd0);
    check("t4_sum",  {24'd0, sum},  32'd0);
    check("t4_cout", {31'd0, cout}, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    check("t4_idle_done", {31'd0, done}, 32'd0);
    check("t4_idle_busy", {31'd0, busy}, 32'd0);
    run_op("t4_after", 8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1);

`ifdef SERIAL_SUB_EN
    // Test 5: subtraction; cin ignored
    run_op("t5a", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    run_op("t5b", 8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1);
    run_op("t5c", 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0);
    run_op("t5d", 8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0);
    run_op("t5e", 8'h42, 8'h42, 1'b0, 1'b1, 8'h00, 1'b1);
    run_op("t5f", 8'h10, 8'h01, 1'b1, 1'b0, 8'h12, 1'b0);
`endif

    // Test 6: random sweep against behavioural a+b+cin
    for (int i = 0; i < 16; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      e  = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      run_op("t6", ra, rb, rc, 1'b0, e[W-1:0], e[W]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
